// File: rtl/l_step_pkg.sv
// Shared types and default sizing for the diffusion-step barrier.
package l_step_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_N_PE        = 8;
    localparam int DEF_DEFAULT_MAX = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/pe_finish_latch.sv
// Sticky per-PE finished latch with enable mask, synchronous clear and
// barrier reduction. Disabled PEs count as already finished.
module pe_finish_latch
    import l_step_pkg::*;
#(
    parameter int N_PE = DEF_N_PE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [N_PE-1:0] mask,
    input  logic [N_PE-1:0] finished,
    output logic [N_PE-1:0] fin_seen,
    output logic            barrier
);

    logic [N_PE-1:0] seen_q;
    logic [N_PE-1:0] seen_d;
    logic [N_PE-1:0] hit;

    assign hit = finished & mask;

    // Per-PE sticky bit: clear wins over a new finished sample.
    for (genvar i = 0; i < N_PE; i++) begin : g_lane
        always_comb begin
            seen_d[i] = seen_q[i];
            if (clr)
                seen_d[i] = 1'b0;
            else if (en)
                seen_d[i] = seen_q[i] | hit[i];
        end
    end

    // Sticky bit register.
    always_ff @(posedge clk) begin
        if (!rst)
            seen_q <= '0;
        else
            seen_q <= seen_d;
    end

    // The finished flag arriving this cycle already counts toward the barrier.
    assign barrier  = &(seen_q | hit | ~mask);
    assign fin_seen = seen_q;

endmodule

// File: rtl/l_step_barrier_multi.sv
// Multi-PE diffusion step barrier: waits for every enabled PE to finish,
// advances l_step, strobes step_pulse, and stops at the captured limit.
// Optional macro L_STEP_CYCLE_COUNT_EN adds the step_cycles output, the
// number of RUN cycles the most recent step took.
module l_step_barrier_multi
    import l_step_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int N_PE        = DEF_N_PE,
    parameter int DEFAULT_MAX = DEF_DEFAULT_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] max_steps_cfg,
    input  logic                  def_on_zero,
    input  logic [N_PE-1:0]       pe_mask,
    input  logic [N_PE-1:0]       finished,
    output logic [DATA_WIDTH-1:0] l_step,
    output logic                  step_pulse,
    output logic                  busy,
    output logic                  done,
    output logic [N_PE-1:0]       fin_seen
`ifdef L_STEP_CYCLE_COUNT_EN
    ,
    output logic [DATA_WIDTH-1:0] step_cycles
`endif
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] l_step_q, l_step_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [N_PE-1:0]       mask_q, mask_d;
    logic                  step_pulse_q, step_pulse_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] cap_max;
    logic [DATA_WIDTH-1:0] l_step_inc;
    logic                  lat_clr;
    logic                  lat_en;
    logic                  barrier;

    assign l_step_inc = l_step_q + 1'b1;

    pe_finish_latch #(
        .N_PE (N_PE)
    ) u_latch (
        .clk      (clk),
        .rst      (rst),
        .clr      (lat_clr),
        .en       (lat_en),
        .mask     (mask_q),
        .finished (finished),
        .fin_seen (fin_seen),
        .barrier  (barrier)
    );

    // Next-state, capture and advance decisions.
    always_comb begin
        state_d      = state_q;
        l_step_d     = l_step_q;
        max_d        = max_q;
        mask_d       = mask_q;
        step_pulse_d = 1'b0;
        lat_clr      = 1'b0;
        lat_en       = 1'b0;
        cap_max      = max_steps_cfg;
        if (max_steps_cfg == '0 && def_on_zero)
            cap_max = DATA_WIDTH'(DEFAULT_MAX);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    max_d    = cap_max;
                    mask_d   = pe_mask;
                    l_step_d = '0;
                    lat_clr  = 1'b1;
                    state_d  = (cap_max == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                lat_en = 1'b1;
                if (barrier) begin
                    l_step_d     = l_step_inc;
                    step_pulse_d = 1'b1;
                    lat_clr      = 1'b1;
                    state_d      = (l_step_inc == max_q) ? ST_DONE : ST_ADVANCE;
                end
            end
            // One dead cycle so PEs can drop finished after step_pulse.
            ST_ADVANCE: state_d = ST_RUN;
            default:    state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_ADVANCE);
        done_d = (state_d == ST_DONE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            l_step_q     <= '0;
            max_q        <= '0;
            mask_q       <= '0;
            step_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            l_step_q     <= l_step_d;
            max_q        <= max_d;
            mask_q       <= mask_d;
            step_pulse_q <= step_pulse_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign l_step     = l_step_q;
    assign step_pulse = step_pulse_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef L_STEP_CYCLE_COUNT_EN
    logic [DATA_WIDTH-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [DATA_WIDTH-1:0] step_cycles_q, step_cycles_d;
    logic [DATA_WIDTH-1:0] cyc_next;

    // Saturating per-step RUN cycle count; the barrier cycle itself is included.
    always_comb begin
        cyc_next      = (&cyc_cnt_q) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
        cyc_cnt_d     = cyc_cnt_q;
        step_cycles_d = step_cycles_q;
        if (state_d == ST_RUN && state_q != ST_RUN)
            cyc_cnt_d = '0;
        else if (state_q == ST_RUN) begin
            cyc_cnt_d = cyc_next;
            if (barrier)
                step_cycles_d = cyc_next;
        end
    end

    // Cycle counter and latched result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_cnt_q     <= '0;
            step_cycles_q <= '0;
        end else begin
            cyc_cnt_q     <= cyc_cnt_d;
            step_cycles_q <= step_cycles_d;
        end
    end

    assign step_cycles = step_cycles_q;
`else
    // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_l_step_barrier_multi.sv
// Directed bench for l_step_barrier_multi (default build, N_PE=8).
module tb_l_step_barrier_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] max_steps_cfg;
    logic        def_on_zero;
    logic [7:0]  pe_mask;
    logic [7:0]  finished;
    logic [31:0] l_step;
    logic        step_pulse;
    logic        busy;
    logic        done;
    logic [7:0]  fin_seen;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    l_step_barrier_multi #(
        .DATA_WIDTH  (32),
        .N_PE        (8),
        .DEFAULT_MAX (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .max_steps_cfg (max_steps_cfg),
        .def_on_zero   (def_on_zero),
        .pe_mask       (pe_mask),
        .finished      (finished),
        .l_step        (l_step),
        .step_pulse    (step_pulse),
        .busy          (busy),
        .done          (done),
        .fin_seen      (fin_seen)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_step, input logic e_pulse,
                           input logic e_busy, input logic e_done);
        chk({tag, ".l_step"}, l_step, e_step);
        chk({tag, ".pulse"}, {31'd0, step_pulse}, {31'd0, e_pulse});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; max_steps_cfg = '0; def_on_zero = 1'b0;
        pe_mask = '0; finished = '0;
        tick(); tick();
        chk_all("reset", 0, 0, 0, 0);
        chk("reset.fin_seen", {24'd0, fin_seen}, 32'h0);
        rst = 1'b1;
        tick();
        chk_all("idle", 0, 0, 0, 0);

        // Full mask, max 3, bits rise one per cycle.
        pe_mask = 8'hFF; max_steps_cfg = 3; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t1.start", 0, 0, 1, 0);
        for (int s = 1; s <= 3; s++) begin
            for (int b = 0; b < 8; b++) begin
                finished = 8'(1 << b);
                tick();
                if (b == 6) begin
                    chk("t1.seen7f", {24'd0, fin_seen}, 32'h7F);
                    chk("t1.nostep", l_step, 32'(s - 1));
                end
            end
            chk_all("t1.adv", 32'(s), 1, (s < 3), (s == 3));
            chk("t1.seen_clr", {24'd0, fin_seen}, 32'h0);
            finished = '0;
            tick();
            chk_all("t1.after", 32'(s), 0, (s < 3), (s == 3));
        end
        finished = 8'hFF;
        tick();
        chk_all("t1.done_hold", 3, 0, 0, 1);
        chk("t1.done_ign", {24'd0, fin_seen}, 32'h0);
        finished = '0;

        // Mask 0x0F with staggered single-cycle pulses.
        pe_mask = 8'h0F; max_steps_cfg = 3; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t2.start", 0, 0, 1, 0);
        finished = 8'h01; tick();
        finished = 8'h00; tick();
        finished = 8'hF2; tick();
        chk("t2.masked", {24'd0, fin_seen}, 32'h03);
        finished = 8'h00; tick();
        finished = 8'h04; tick();
        finished = 8'h00; tick();
        chk("t2.seen07", {24'd0, fin_seen}, 32'h07);
        chk("t2.wait", l_step, 0);
        finished = 8'h08; tick();
        chk_all("t2.step1", 1, 1, 1, 0);
        finished = 8'h00; tick();
        chk_all("t2.run", 1, 0, 1, 0);
        // Held finished through ADVANCE must count once.
        finished = 8'h0F; tick();
        chk_all("t2.step2", 2, 1, 1, 0);
        tick();
        chk_all("t2.advance", 2, 0, 1, 0);
        chk("t2.adv_seen", {24'd0, fin_seen}, 32'h0);
        finished = 8'h00; start = 1'b1; max_steps_cfg = 0;
        tick();
        start = 1'b0;
        chk_all("t2.start_ign", 2, 0, 1, 0);
        finished = 8'h0F; tick();
        chk_all("t2.step3", 3, 1, 0, 1);
        finished = 8'h00;

        // Zero limit without default -> immediate DONE.
        pe_mask = 8'hFF; max_steps_cfg = 0; def_on_zero = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t3.zero", 0, 0, 0, 1);
        tick();
        chk_all("t3.zero2", 0, 0, 0, 1);

        // Zero limit with default, empty mask -> 7 pulses 2 cycles apart.
        pe_mask = 8'h00; def_on_zero = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; def_on_zero = 1'b0;
        chk_all("t3.run", 0, 0, 1, 0);
        for (int s = 1; s <= 7; s++) begin
            tick();
            chk_all("t3.pulse", 32'(s), 1, (s < 7), (s == 7));
            tick();
            chk_all("t3.gap", 32'(s), 0, (s < 7), (s == 7));
        end

        // Reset mid-run at l_step=2, with start asserted alongside.
        pe_mask = 8'hFF; max_steps_cfg = 5; start = 1'b1;
        tick();
        start = 1'b0;
        finished = 8'hFF; tick();
        finished = 8'h00; tick();
        finished = 8'hFF; tick();
        chk_all("t4.step2", 2, 1, 1, 0);
        finished = 8'h00; tick();
        finished = 8'h03; tick();
        chk("t4.seen03", {24'd0, fin_seen}, 32'h03);
        rst = 1'b0; start = 1'b1; finished = 8'h00;
        tick();
        chk_all("t4.rst", 0, 0, 0, 0);
        chk("t4.rst_seen", {24'd0, fin_seen}, 32'h0);
        rst = 1'b1; start = 1'b0;
        tick();
        chk_all("t4.idle", 0, 0, 0, 0);
        pe_mask = 8'h01; max_steps_cfg = 1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t4.restart", 0, 0, 1, 0);
        finished = 8'h01; tick();
        chk_all("t4.final", 1, 1, 0, 1);
        finished = 8'h00; tick();
        chk_all("t4.hold", 1, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
